// File: rtl/clk_rate_pkg.sv
// clk_rate_pkg: shared constants and state encoding for the clock rate scheduler
package clk_rate_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        GATE    = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        NEXT    = 3'd5
    } state_t;

    localparam int DEFAULT_GATE_CYCLES = 1250000;
    localparam int HZ_PER_LSB          = 100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clk_rate_counter.sv
// clk_rate_counter: test-domain rate counter with gate synchronizer and async clear
module clk_rate_counter #(
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          gate,
    output logic [CW-1:0] count
);

    logic [1:0] gate_sync;

    // count test-clock edges while the synchronized gate is high; clear is asynchronous
    always_ff @(posedge clk or posedge clear)
        if (clear) begin
            gate_sync <= '0;
            count     <= '0;
        end else begin
            gate_sync <= {gate_sync[0], gate};
            if (gate_sync[1])
                count <= count + 1'b1;
        end

endmodule

// File: rtl/clk_rate_scheduler.sv
// clk_rate_scheduler: sequences clear/gate/capture over NCH rate counters and keeps a result file
module clk_rate_scheduler
    import clk_rate_pkg::*;
#(
    parameter int NCH           = 8,
    parameter int CW            = 24,
    parameter int GATE_CYCLES   = DEFAULT_GATE_CYCLES,
    parameter int CLEAR_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 8,
    localparam int CHW          = $clog2(NCH),
    localparam int TW           = $clog2(max3(GATE_CYCLES, CLEAR_CYCLES, SETTLE_CYCLES)) + 1
) (
    input  logic              clk125,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear_results,
    input  logic [CW-1:0]     rate_lo,
    input  logic [CW-1:0]     rate_hi,
    input  logic [NCH*CW-1:0] meas_count,
    output logic [NCH-1:0]    meas_clear,
    output logic [NCH-1:0]    meas_gate,
    output logic [CHW-1:0]    cur_ch,
    output logic              sweep_done,
    input  logic [CHW-1:0]    rd_sel,
    output logic [CW-1:0]     rd_rate,
    output logic              rd_valid,
    output logic              rd_err
);

    state_t         state;
    logic [TW-1:0]  timer;
    logic [CHW-1:0] ch;
    logic [CHW-1:0] next_ch;
    logic           last_ch;
    logic [NCH-1:0] ch_bit;
    logic [NCH-1:0] next_bit;
    logic [CW-1:0]  cap;
    logic           cap_err;
    logic           rd_ok;
    logic [CW-1:0]  rate [NCH];
    logic [NCH-1:0] valid;
    logic [NCH-1:0] err;

    assign cur_ch   = ch;
    assign last_ch  = ch == CHW'(NCH - 1);
    assign next_ch  = last_ch ? '0 : ch + 1'b1;
    assign ch_bit   = NCH'(1) << ch;
    assign next_bit = NCH'(1) << next_ch;
    assign cap      = meas_count[int'(ch)*CW +: CW];
    assign cap_err  = (cap < rate_lo) || (cap > rate_hi);

    // measurement sequencer: one channel at a time, window lengths set by a down-counting timer
    always_ff @(posedge clk125 or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            ch         <= '0;
            meas_clear <= '0;
            meas_gate  <= '0;
            sweep_done <= 1'b0;
        end else if (!enable) begin
            state      <= IDLE;
            timer      <= '0;
            ch         <= '0;
            meas_clear <= '0;
            meas_gate  <= '0;
            sweep_done <= 1'b0;
        end else begin
            meas_clear <= '0;
            meas_gate  <= '0;
            sweep_done <= 1'b0;
            timer      <= timer - 1'b1;
            case (state)
                IDLE: begin
                    state      <= CLEAR;
                    timer      <= TW'(CLEAR_CYCLES - 1);
                    meas_clear <= ch_bit;
                end
                CLEAR:
                    if (timer == '0) begin
                        state     <= GATE;
                        timer     <= TW'(GATE_CYCLES - 1);
                        meas_gate <= ch_bit;
                    end else
                        meas_clear <= ch_bit;
                GATE:
                    if (timer == '0) begin
                        state <= SETTLE;
                        timer <= TW'(SETTLE_CYCLES - 1);
                    end else
                        meas_gate <= ch_bit;
                SETTLE:
                    if (timer == '0)
                        state <= CAPTURE;
                CAPTURE: begin
                    state      <= NEXT;
                    sweep_done <= last_ch;
                end
                NEXT: begin
                    state      <= CLEAR;
                    ch         <= next_ch;
                    timer      <= TW'(CLEAR_CYCLES - 1);
                    meas_clear <= next_bit;
                end
                default: state <= IDLE;
            endcase
        end

    // result file: bulk clear of flags, with a same-cycle capture taking priority for its channel
    always_ff @(posedge clk125 or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++)
                rate[i] <= '0;
            valid <= '0;
            err   <= '0;
        end else begin
            if (clear_results) begin
                valid <= '0;
                err   <= '0;
            end
            if (enable && state == CAPTURE) begin
                rate[ch]  <= cap;
                valid[ch] <= 1'b1;
                err[ch]   <= cap_err;
            end
        end

    assign rd_ok    = int'(rd_sel) < NCH;
    assign rd_rate  = rd_ok ? rate[rd_sel] : '0;
    assign rd_valid = rd_ok && valid[rd_sel];
    assign rd_err   = rd_ok && err[rd_sel];

endmodule

// File: tb/tb_clk_rate_scheduler.sv
// tb_clk_rate_scheduler: directed table-driven check of the rate scheduler with modelled counters
module tb_clk_rate_scheduler;

    localparam int CW = 24;

    logic          clk125 = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear_results = 1'b0;
    logic [CW-1:0] rate_lo = '0;
    logic [CW-1:0] rate_hi = '0;
    logic [2*CW-1:0] meas_count;
    logic [1:0]    meas_clear, meas_gate;
    logic          cur_ch;
    logic          sweep_done;
    logic          rd_sel = 1'b0;
    logic [CW-1:0] rd_rate;
    logic          rd_valid, rd_err;

    logic          en3 = 1'b0;
    logic          clr3 = 1'b0;
    logic [CW-1:0] lo3 = 24'd15;
    logic [CW-1:0] hi3 = 24'd25;
    logic [3*CW-1:0] mc3 = {24'd30, 24'd20, 24'd10};
    logic [2:0]    mclr3, mgate3;
    logic [1:0]    cur3;
    logic          sd3;
    logic [1:0]    sel3 = 2'd0;
    logic [CW-1:0] rate3;
    logic          valid3, err3;

    int nvec = 0;
    int nbad = 0;

    always #4 clk125 = ~clk125;

    clk_rate_scheduler #(.NCH(2), .CW(CW), .GATE_CYCLES(100), .CLEAR_CYCLES(4), .SETTLE_CYCLES(4)) dut (
        .clk125(clk125), .reset_n(reset_n), .enable(enable), .clear_results(clear_results),
        .rate_lo(rate_lo), .rate_hi(rate_hi), .meas_count(meas_count),
        .meas_clear(meas_clear), .meas_gate(meas_gate), .cur_ch(cur_ch), .sweep_done(sweep_done),
        .rd_sel(rd_sel), .rd_rate(rd_rate), .rd_valid(rd_valid), .rd_err(rd_err)
    );

    clk_rate_scheduler #(.NCH(3), .CW(CW), .GATE_CYCLES(100), .CLEAR_CYCLES(4), .SETTLE_CYCLES(4)) dut3 (
        .clk125(clk125), .reset_n(reset_n), .enable(en3), .clear_results(clr3),
        .rate_lo(lo3), .rate_hi(hi3), .meas_count(mc3),
        .meas_clear(mclr3), .meas_gate(mgate3), .cur_ch(cur3), .sweep_done(sd3),
        .rd_sel(sel3), .rd_rate(rate3), .rd_valid(valid3), .rd_err(err3)
    );

    // counter models: ch0 runs at 125 MHz, ch1 at 62.5 MHz or stopped when dead
    logic [CW-1:0] cnt0 = '0;
    logic [CW-1:0] cnt1 = '0;
    logic          ph = 1'b0;
    logic          dead = 1'b0;
    int            clr_hi0 = 0;
    int            clr_hi1 = 0;
    int            onehot_bad = 0;
    int            sd_seen = 0;

    assign meas_count = {cnt1, cnt0};

    always @(posedge clk125) begin
        ph <= ~ph;
        if (meas_clear[0]) cnt0 <= '0;
        else if (meas_gate[0]) cnt0 <= cnt0 + 1'b1;
        if (meas_clear[1]) cnt1 <= '0;
        else if (meas_gate[1] && ph && !dead) cnt1 <= cnt1 + 1'b1;
        if (meas_clear[0]) clr_hi0 <= clr_hi0 + 1;
        if (meas_clear[1]) clr_hi1 <= clr_hi1 + 1;
        if ($countones({meas_clear, meas_gate}) > 1) onehot_bad <= onehot_bad + 1;
        if (sweep_done) sd_seen <= sd_seen + 1;
    end

    typedef struct {
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic          dead;
        logic [CW-1:0] r0;
        logic          e0;
        logic [CW-1:0] r1;
        logic          e1;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk125);
            #1;
        end
    endtask

    task automatic wait_sd(input bit which3, output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            n++;
            if (which3 ? sd3 : sweep_done) return;
        end
        n = -1;
    endtask

    task automatic chk_ch(input string nm, input logic s, input logic [CW-1:0] r, input logic v, input logic e);
        rd_sel = s;
        #1;
        chk({nm, "_rate"}, 32'(rd_rate), 32'(r));
        chk({nm, "_valid"}, 32'(rd_valid), 32'(v));
        chk({nm, "_err"}, 32'(rd_err), 32'(e));
    endtask

    initial begin
        int n;
        int c0, c1, sd0;
        vt[0] = '{24'd40,  24'd100, 1'b0, 24'd100, 1'b0, 24'd50, 1'b0};
        vt[1] = '{24'd40,  24'd100, 1'b1, 24'd100, 1'b0, 24'd0,  1'b1};
        vt[2] = '{24'd50,  24'd100, 1'b0, 24'd100, 1'b0, 24'd50, 1'b0};
        vt[3] = '{24'd51,  24'd99,  1'b0, 24'd100, 1'b1, 24'd50, 1'b1};
        vt[4] = '{24'd0,   24'd0,   1'b1, 24'd100, 1'b1, 24'd0,  1'b0};
        vt[5] = '{24'd200, 24'd100, 1'b0, 24'd100, 1'b1, 24'd50, 1'b1};

        #2;
        chk("rst_clear", 32'(meas_clear), 0);
        chk("rst_gate", 32'(meas_gate), 0);
        chk("rst_cur_ch", 32'(cur_ch), 0);
        chk("rst_sweep_done", 32'(sweep_done), 0);
        chk_ch("rst_ch0", 1'b0, '0, 1'b0, 1'b0);
        step(3);
        @(negedge clk125);
        reset_n = 1'b1;
        step(2);
        chk("idle_clear", 32'(meas_clear), 0);

        foreach (vt[i]) begin
            rate_lo = vt[i].lo;
            rate_hi = vt[i].hi;
            dead    = vt[i].dead;
            c0 = clr_hi0;
            c1 = clr_hi1;
            enable = 1'b1;
            wait_sd(1'b0, n);
            chk($sformatf("v%0d_sweep_len", i), 32'(n), 220);
            enable = 1'b0;
            step(2);
            chk($sformatf("v%0d_clr0_len", i), 32'(clr_hi0 - c0), 4);
            chk($sformatf("v%0d_clr1_len", i), 32'(clr_hi1 - c1), 4);
            chk_ch($sformatf("v%0d_ch0", i), 1'b0, vt[i].r0, 1'b1, vt[i].e0);
            chk_ch($sformatf("v%0d_ch1", i), 1'b1, vt[i].r1, 1'b1, vt[i].e1);
        end

        rate_lo = 24'd40;
        rate_hi = 24'd100;
        dead = 1'b0;
        sd0 = sd_seen;
        enable = 1'b1;
        step(164);
        chk("abort_pre_gate", 32'(meas_gate), 2);
        chk("abort_pre_ch", 32'(cur_ch), 1);
        enable = 1'b0;
        step(1);
        chk("abort_gate", 32'(meas_gate), 0);
        chk("abort_cur_ch", 32'(cur_ch), 0);
        step(300);
        chk("abort_clear_idle", 32'(meas_clear), 0);
        chk("abort_no_sweep", 32'(sd_seen - sd0), 0);
        chk_ch("abort_ch0", 1'b0, 24'd100, 1'b1, 1'b0);
        chk_ch("abort_ch1", 1'b1, 24'd50, 1'b1, 1'b1);

        enable = 1'b1;
        step(109);
        clear_results = 1'b1;
        step(1);
        clear_results = 1'b0;
        enable = 1'b0;
        step(1);
        chk_ch("cc_ch0", 1'b0, 24'd100, 1'b1, 1'b0);
        chk_ch("cc_ch1", 1'b1, 24'd50, 1'b0, 1'b0);

        enable = 1'b1;
        step(30);
        chk("mid_gate", 32'(meas_gate), 1);
        @(negedge clk125);
        reset_n = 1'b0;
        #1;
        chk("arst_gate", 32'(meas_gate), 0);
        chk("arst_clear", 32'(meas_clear), 0);
        chk("arst_cur_ch", 32'(cur_ch), 0);
        chk_ch("arst_ch0", 1'b0, '0, 1'b0, 1'b0);
        enable = 1'b0;
        step(2);
        @(negedge clk125);
        reset_n = 1'b1;
        step(1);
        enable = 1'b1;
        step(1);
        chk("post_rst_clear", 32'(meas_clear), 1);
        chk("post_rst_gate", 32'(meas_gate), 0);
        enable = 1'b0;
        step(2);

        en3 = 1'b1;
        wait_sd(1'b1, n);
        chk("d3_sweep_len", 32'(n), 330);
        en3 = 1'b0;
        step(2);
        for (int s = 0; s < 4; s++) begin
            sel3 = 2'(s);
            #1;
            chk($sformatf("d3_rate%0d", s), 32'(rate3), (s == 3) ? 0 : 10 * (s + 1));
            chk($sformatf("d3_valid%0d", s), 32'(valid3), (s == 3) ? 0 : 1);
            chk($sformatf("d3_err%0d", s), 32'(err3), (s == 1 || s == 3) ? 0 : 1);
        end

        chk("onehot", 32'(onehot_bad), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
